accumulator_subtractor: RTL and testbench

- Registered single-precision (IEEE-754 binary32) running subtractor for the softmax datapath.
- Every clock cycle it subtracts the input operand from an internal accumulator and updates the accumulator with the difference.
- The accumulator is exposed as result, so it decrements by inp each cycle.
- Used where a repeated floating-point subtraction must be carried across cycles.

---
 rtl/accumulator_subtractor.sv | 145 ++++++++++++++
 tb/tb_accumulator_subtractor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/accumulator_subtractor.sv
// Running binary32 subtractor: every clock edge acc <= acc - inp, and result shows acc.
// The subtraction is an IEEE round-to-nearest-even add with the subtrahend's sign flipped.
// Subnormal operands and subnormal results are flushed to zero.
module accumulator_subtractor (
   input  logic [31:0] inp,
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] result
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic [31:0] acc_q;
   logic [31:0] acc_d;

   // Operand fields; b is the subtrahend with its sign already inverted (a - b == a + (-b))
   logic        a_sign, b_sign;
   logic [7:0]  a_exp, b_exp;
   logic [22:0] a_frac, b_frac;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign a_sign = acc_q[31];
   assign a_exp  = acc_q[30:23];
   assign a_frac = acc_q[22:0];
   assign b_sign = ~inp[31];
   assign b_exp  = inp[30:23];
   assign b_frac = inp[22:0];

   assign a_zero = (a_exp == 8'd0);
   assign b_zero = (b_exp == 8'd0);
   assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
   assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
   assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
   assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);

   logic        x_sign, y_sign;
   logic [7:0]  x_exp, y_exp;
   logic [23:0] x_mant, y_mant;
   logic [7:0]  exp_diff;
   logic [4:0]  shamt;
   logic [52:0] shift_tmp;
   logic [26:0] y_aligned;
   logic [27:0] sum;
   logic [4:0]  lz;
   logic [26:0] norm;
   logic [9:0]  exp_n;
   logic [9:0]  exp_r;
   logic        round_up;
   logic [24:0] mant_r;
   logic [22:0] frac_r;
   logic [31:0] diff;

   // Order operands by magnitude, align the smaller one (guard/round/sticky kept), then add or subtract
   always_comb begin
      x_sign = a_sign;
      y_sign = b_sign;
      x_exp  = a_exp;
      y_exp  = b_exp;
      x_mant = a_zero ? 24'd0 : {1'b1, a_frac};
      y_mant = b_zero ? 24'd0 : {1'b1, b_frac};
      if ({b_exp, b_frac} > {a_exp, a_frac}) begin
         x_sign = b_sign;
         y_sign = a_sign;
         x_exp  = b_exp;
         y_exp  = a_exp;
         x_mant = b_zero ? 24'd0 : {1'b1, b_frac};
         y_mant = a_zero ? 24'd0 : {1'b1, a_frac};
      end
      exp_diff  = x_exp - y_exp;
      shamt     = (exp_diff > 8'd31) ? 5'd31 : exp_diff[4:0];
      // Beyond 26 places the whole mantissa lands in the sticky bits, so 31 is a safe cap
      shift_tmp = {y_mant, 29'd0} >> shamt;
      y_aligned = {shift_tmp[52:27], shift_tmp[26] | (|shift_tmp[25:0])};
      if (x_sign ^ y_sign) begin
         sum = {1'b0, x_mant, 3'b000} - {1'b0, y_aligned};
      end else begin
         sum = {1'b0, x_mant, 3'b000} + {1'b0, y_aligned};
      end
   end

   // Normalise (right by one on carry-out, else left by the leading-zero count) and round to nearest even
   always_comb begin
      lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) begin
            lz = 5'(26 - i);
         end
      end
      if (sum[27]) begin
         norm  = {sum[27:2], sum[1] | sum[0]};
         exp_n = {2'b00, x_exp} + 10'd1;
      end else begin
         norm  = sum[26:0] << lz;
         exp_n = {2'b00, x_exp} - {5'd0, lz};
      end
      round_up = norm[2] & ((|norm[1:0]) | norm[3]);
      mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
      if (mant_r[24]) begin
         exp_r  = exp_n + 10'd1;
         frac_r = mant_r[23:1];
      end else begin
         exp_r  = exp_n;
         frac_r = mant_r[22:0];
      end
   end

   // Special operands and exponent range checks override the arithmetic result
   always_comb begin
      diff = {x_sign, exp_r[7:0], frac_r};
      if (a_nan || b_nan) begin
         diff = QNAN;
      end else if (a_inf && b_inf) begin
         diff = (a_sign == b_sign) ? {a_sign, 8'hFF, 23'd0} : QNAN;
      end else if (a_inf) begin
         diff = {a_sign, 8'hFF, 23'd0};
      end else if (b_inf) begin
         diff = {b_sign, 8'hFF, 23'd0};
      end else if (a_zero && b_zero) begin
         diff = {a_sign & b_sign, 31'd0};
      end else if (sum == 28'd0) begin
         diff = 32'd0;
      end else if (exp_r[9] || (exp_r == 10'd0)) begin
         diff = 32'd0;
      end else if (exp_r >= 10'd255) begin
         diff = {x_sign, 8'hFF, 23'd0};
      end
   end

   // Next accumulator value is the difference; reset wins inside the register
   always_comb begin
      acc_d = diff;
   end

   // Accumulator register with synchronous clear to +0.0
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= 32'd0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign result = acc_q;

endmodule

// File: tb/tb_accumulator_subtractor.sv
// Directed bench for accumulator_subtractor with an exact-arithmetic reference model.
module tb_accumulator_subtractor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inp;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_acc   = 32'd0;
   logic        model_valid = 1'b0;

   accumulator_subtractor dut (
      .inp    (inp),
      .clk    (clk),
      .reset  (reset),
      .result (result)
   );

   always #5 clk = ~clk;

   // Reference: exact difference in a wide fixed-point integer (value * 2^150), then RNE to binary32
   function automatic logic [31:0] fp_sub_model(input logic [31:0] a, input logic [31:0] b);
      logic [299:0] ma, mb, mag, rem, half;
      logic         sa, sb, sr;
      int           p, sh, e;
      logic [24:0]  m;
      logic         a_nan, b_nan, a_inf, b_inf;
      sa    = a[31];
      sb    = ~b[31];
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      if (a_nan || b_nan) return 32'h7FC00000;
      if (a_inf && b_inf) return (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC00000;
      if (a_inf) return {sa, 8'hFF, 23'd0};
      if (b_inf) return {sb, 8'hFF, 23'd0};
      ma = (a[30:23] == 0) ? 300'd0 : (300'({1'b1, a[22:0]}) << a[30:23]);
      mb = (b[30:23] == 0) ? 300'd0 : (300'({1'b1, b[22:0]}) << b[30:23]);
      if (ma == 0 && mb == 0) return {sa & sb, 31'd0};
      if (sa == sb) begin
         mag = ma + mb; sr = sa;
      end else if (ma >= mb) begin
         mag = ma - mb; sr = sa;
      end else begin
         mag = mb - ma; sr = sb;
      end
      if (mag == 0) return 32'd0;
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      if (p < 24) return 32'd0;
      sh   = p - 23;
      m    = 25'(mag >> sh);
      rem  = mag & ((300'd1 << sh) - 300'd1);
      half = (sh > 0) ? (300'd1 << (sh - 1)) : 300'd0;
      if (sh > 0 && (rem > half || (rem == half && m[0]))) m = m + 25'd1;
      e = p - 23;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {sr, 8'hFF, 23'd0};
      return {sr, 8'(e), m[22:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
      end
   endtask

   // Apply one edge of stimulus and check the registered result against a hand-computed value
   task automatic apply(input logic rst, input logic [31:0] val, input logic [31:0] exp_v, input string name);
      @(negedge clk);
      reset = rst;
      inp   = val;
      @(posedge clk);
      #1;
      $display("txn %-14s reset=%0b inp=%08h result=%08h expect=%08h", name, rst, val, result, exp_v);
      check(name, result, exp_v);
   endtask

   // Apply one edge of stimulus checked only by the reference model
   task automatic drive(input logic rst, input logic [31:0] val);
      @(negedge clk);
      reset = rst;
      inp   = val;
      @(posedge clk);
      #1;
      $display("txn %-14s reset=%0b inp=%08h result=%08h", "model_only", rst, val, result);
   endtask

   // Reference model follows the same inputs on every edge
   always @(posedge clk) begin
      if (reset) model_acc <= 32'd0;
      else       model_acc <= fp_sub_model(model_acc, inp);
      model_valid <= 1'b1;
   end

   // Continuous comparison of the DUT against the model, away from the active edge
   always @(negedge clk) begin
      if (model_valid) check("model", result, model_acc);
   end

   logic [31:0] minus_n [12] = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000,
                                 32'hC0A00000, 32'hC0C00000, 32'hC0E00000, 32'hC1000000,
                                 32'hC1100000, 32'hC1200000, 32'hC1300000, 32'hC1400000};

   initial begin
      reset = 1'b1;
      inp   = 32'h3F800000;

      // Literal pins on the model itself
      check("pin_tie_up",   fp_sub_model(32'h3F800000, 32'hB3800000), 32'h3F800000);
      check("pin_exact",    fp_sub_model(32'hB3800000, 32'hBF800000), 32'h3F7FFFFF);
      check("pin_pi_m1",    fp_sub_model(32'h40490FDB, 32'h3F800000), 32'h40090FDB);
      check("pin_negzero",  fp_sub_model(32'h80000000, 32'h00000000), 32'h80000000);

      // Reset, then repeated subtraction of 1.0
      apply(1'b1, 32'h3F800000, 32'h00000000, "reset");
      for (int i = 0; i < 12; i++) apply(1'b0, 32'h3F800000, minus_n[i], $sformatf("dec_%0d", i + 1));

      // Mid-operation reset
      apply(1'b1, 32'h3F800000, 32'h00000000, "reset2");
      for (int i = 0; i < 4; i++) apply(1'b0, 32'h3F800000, minus_n[i], $sformatf("pre_%0d", i + 1));
      apply(1'b1, 32'h40000000, 32'h00000000, "mid_reset");
      apply(1'b0, 32'h40000000, 32'hC0000000, "two_1");
      apply(1'b0, 32'h40000000, 32'hC0800000, "two_2");

      // Exact cancellation gives +0
      apply(1'b1, 32'h3F800000, 32'h00000000, "reset3");
      for (int i = 0; i < 3; i++) apply(1'b0, 32'h3F800000, minus_n[i], $sformatf("c_%0d", i + 1));
      apply(1'b0, 32'hC0400000, 32'h00000000, "cancel");

      // Rounding: exact result, ties to even, above-half rounding
      apply(1'b1, 32'h00000000, 32'h00000000, "reset4");
      apply(1'b0, 32'h33800000, 32'hB3800000, "tiny");
      apply(1'b0, 32'hBF800000, 32'h3F7FFFFF, "one_m_tiny");
      apply(1'b1, 32'h00000000, 32'h00000000, "reset5");
      apply(1'b0, 32'hBF800000, 32'h3F800000, "one");
      apply(1'b0, 32'hB3800000, 32'h3F800000, "tie_down");
      apply(1'b0, 32'h33000000, 32'h3F800000, "tie_below");
      apply(1'b0, 32'hB3800001, 32'h3F800001, "above_half");
      apply(1'b0, 32'hB3800000, 32'h3F800002, "tie_up_even");

      // Overflow, Inf - Inf, NaN persistence
      apply(1'b1, 32'h00000000, 32'h00000000, "reset6");
      apply(1'b0, 32'h7F7FFFFF, 32'hFF7FFFFF, "neg_max");
      apply(1'b0, 32'h7F7FFFFF, 32'hFF800000, "overflow");
      apply(1'b0, 32'hFF800000, 32'h7FC00000, "inf_m_inf");
      apply(1'b0, 32'h3F800000, 32'h7FC00000, "nan_sticky");
      apply(1'b1, 32'h3F800000, 32'h00000000, "nan_cleared");

      // Subnormal flush and smallest normals
      apply(1'b0, 32'h00000001, 32'h00000000, "sub_flush");
      apply(1'b0, 32'h00800000, 32'h80800000, "min_norm_1");
      apply(1'b0, 32'h00800000, 32'h81000000, "min_norm_2");

      // Infinite and NaN operands
      apply(1'b1, 32'h00000000, 32'h00000000, "reset7");
      apply(1'b0, 32'h7F800000, 32'hFF800000, "fin_m_inf");
      apply(1'b0, 32'h3F800000, 32'hFF800000, "inf_m_fin");
      apply(1'b1, 32'h00000000, 32'h00000000, "reset8");
      apply(1'b0, 32'h7FC00001, 32'h7FC00000, "nan_in");

      // Mixed magnitudes
      apply(1'b1, 32'h00000000, 32'h00000000, "reset9");
      apply(1'b0, 32'hC0490FDB, 32'h40490FDB, "pi");
      apply(1'b0, 32'h3F800000, 32'h40090FDB, "pi_m1");
      drive(1'b0, 32'h4B800000);
      drive(1'b0, 32'h3F000000);
      drive(1'b0, 32'hC7F12345);
      drive(1'b0, 32'h00FFFFFF);
      drive(1'b0, 32'h33800000);
      drive(1'b0, 32'hC7F12300);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
